// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder family (leaf slice and second-level unit).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cla_pkg;

  localparam int CLA_WIDTH = 4;

  // Result bundle of one adder slice, also the payload of its optional output register.
  typedef struct packed {
    logic [CLA_WIDTH-1:0] s;
    logic                 co;
    logic                 pg;
    logic                 gg;
  } cla_out_t;

  // Value the output register takes while reset is held.
  localparam cla_out_t CLA_OUT_RST = '{s: '0, co: 1'b0, pg: 1'b0, gg: 1'b0};

endpackage

// File: rtl/cla_pfa.sv
// Partial full adder: bit propagate/generate plus sum bit for a supplied carry.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
module cla_pfa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic p,
  output logic g,
  output logic s
);

  assign p = a ^ b;
  assign g = a & b;
  assign s = p ^ c;

endmodule

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder slice with group propagate/generate for cascading.
// Latency: 0 cycles when OUT_REG=0, 1 cycle when OUT_REG=1 (async reset clears the register).
// Backpressure: none; a new result every cycle, no handshake.
module cla4
  import cla_pkg::*;
#(
  parameter bit OUT_REG = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CLA_WIDTH-1:0] A,
  input  logic [CLA_WIDTH-1:0] B,
  input  logic                 Ci,
  output logic [CLA_WIDTH-1:0] S,
  output logic                 Co,
  output logic                 PG,
  output logic                 GG
);

  logic [CLA_WIDTH-1:0] p;
  logic [CLA_WIDTH-1:0] g;
  logic [CLA_WIDTH-1:0] c;
  logic [CLA_WIDTH-1:0] s_w;
  logic                 pg_w;
  logic                 gg_w;
  logic                 c4;
  cla_out_t             res;
  cla_out_t             out_b;

  // One partial full adder per bit; carries come in from the lookahead block.
  for (genvar i = 0; i < CLA_WIDTH; i++) begin : g_pfa
    cla_pfa u_pfa (
      .a (A[i]),
      .b (B[i]),
      .c (c[i]),
      .p (p[i]),
      .g (g[i]),
      .s (s_w[i])
    );
  end

  // Every carry is a flat sum of products over p/g/Ci so no bit waits on its neighbour.
  // Ci is used directly rather than c[0] to keep each carry a function of primary terms only.
  assign c[0] = Ci;
  assign c[1] = g[0] | (p[0] & Ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Ci);

  // Group terms are carry-independent so a second-level unit can use them before Ci settles.
  assign pg_w = &p;
  assign gg_w = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign c4   = gg_w | (pg_w & Ci);

  assign res = '{s: s_w, co: c4, pg: pg_w, gg: gg_w};

  if (OUT_REG) begin : g_reg
    cla_out_t out_q;

    // Output register: reset clears it at once, otherwise capture the fresh result every edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q <= CLA_OUT_RST;
      end else begin
        out_q <= res;
      end
    end

    assign out_b = out_q;
  end else begin : g_comb
    // Clock and reset are intentionally unused in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_b = res;
  end

  assign S  = out_b.s;
  assign Co = out_b.co;
  assign PG = out_b.pg;
  assign GG = out_b.gg;

endmodule

// File: tb/tb_cla4.sv
// Self-checking bench for cla4: directed table, exhaustive sweep (combinational build),
// and latency/reset sequences on a registered build.
module tb_cla4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a0, b0, a1, b1;
  logic       ci0, ci1;
  logic [3:0] s0, s1;
  logic       co0, pg0, gg0, co1, pg1, gg1;

  int checks = 0;
  int errors = 0;
  int sweep_vecs = 0;

  always #5 clk = ~clk;

  cla4 #(.OUT_REG(1'b0)) u_comb (
    .clk (clk), .rst (rst), .A (a0), .B (b0), .Ci (ci0),
    .S (s0), .Co (co0), .PG (pg0), .GG (gg0)
  );

  cla4 #(.OUT_REG(1'b1)) u_reg (
    .clk (clk), .rst (rst), .A (a1), .B (b1), .Ci (ci1),
    .S (s1), .Co (co1), .PG (pg1), .GG (gg1)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] s;
    logic       co;
    logic       pg;
    logic       gg;
  } vec_t;

  vec_t tbl [10];

  // Compare a packed {S,Co,PG,GG} against the expectation.
  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got S=%b Co=%b PG=%b GG=%b, want S=%b Co=%b PG=%b GG=%b",
               name, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [6:0] pack(input logic [3:0] s, input logic co, input logic pg, input logic gg);
    return {s, co, pg, gg};
  endfunction

  initial begin
    //            a        b        ci    s        co    pg    gg
    tbl[0] = '{4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{4'b0110, 4'b0011, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{4'b1100, 4'b0101, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    a0 = '0; b0 = '0; ci0 = 1'b0;
    a1 = 4'b1111; b1 = 4'b1111; ci1 = 1'b1;

    // Registered build under reset: zero, and stays zero across edges.
    #1;
    chk("reset_state", pack(s1, co1, pg1, gg1), 7'b0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_hold_over_edges", pack(s1, co1, pg1, gg1), 7'b0);

    // Directed table on the combinational build.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      a0 = tbl[i].a; b0 = tbl[i].b; ci0 = tbl[i].ci;
      @(negedge clk);
      chk($sformatf("table_%0d", i), pack(s0, co0, pg0, gg0),
          pack(tbl[i].s, tbl[i].co, tbl[i].pg, tbl[i].gg));
    end

    // Release reset between edges; nothing loads until the next rising edge.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reg_before_edge", pack(s1, co1, pg1, gg1), 7'b0);
    @(posedge clk); #1;
    chk("reg_after_edge_max", pack(s1, co1, pg1, gg1), pack(4'b1111, 1'b1, 1'b0, 1'b1));

    // Inputs change mid-cycle: output holds, then updates on the edge.
    a1 = 4'b0101; b1 = 4'b0011; ci1 = 1'b0;
    @(negedge clk);
    chk("reg_hold_between_edges", pack(s1, co1, pg1, gg1), pack(4'b1111, 1'b1, 1'b0, 1'b1));
    @(posedge clk); #1;
    chk("reg_next_result", pack(s1, co1, pg1, gg1), pack(4'b1000, 1'b0, 1'b0, 1'b0));

    // Load a nonzero result, then assert reset between edges.
    a1 = 4'b1111; b1 = 4'b0001; ci1 = 1'b0;
    @(posedge clk); #1;
    chk("reg_before_midreset", pack(s1, co1, pg1, gg1), pack(4'b0000, 1'b1, 1'b0, 1'b1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_immediate", pack(s1, co1, pg1, gg1), 7'b0);
    a1 = 4'b1100; b1 = 4'b0101; ci1 = 1'b0;
    @(posedge clk); #1;
    chk("midreset_discard_inflight", pack(s1, co1, pg1, gg1), 7'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_release_no_edge", pack(s1, co1, pg1, gg1), 7'b0);
    @(posedge clk); #1;
    chk("reload_after_reset", pack(s1, co1, pg1, gg1), pack(4'b0001, 1'b1, 1'b0, 1'b1));

    // Exhaustive sweep of the combinational build; model is plain integer arithmetic.
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      logic [4:0] sum;
      logic [4:0] ab;
      vv = v[8:0];
      @(posedge clk); #1;
      {a0, b0, ci0} = vv;
      ab  = {1'b0, vv[8:5]} + {1'b0, vv[4:1]};
      sum = ab + {4'b0, vv[0]};
      @(negedge clk);
      sweep_vecs++;
      chk($sformatf("sweep_a%0d_b%0d_ci%0d", vv[8:5], vv[4:1], vv[0]),
          pack(s0, co0, pg0, gg0), pack(sum[3:0], sum[4], (ab == 5'd15), ab[4]));
    end
    $display("sweep vectors %0d", sweep_vecs);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
